// File: rtl/fp16_to_fixed_seq.sv
// Batch FP16 -> signed fixed-point converter. A whole batch is captured at once,
// then lanes are converted one per cycle through a single shared converter.
module fp16_to_fixed_seq #(
    parameter int CHANNELS  = 4,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*CHANNELS-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W*CHANNELS-1:0] out_data,
    output logic [CHANNELS-1:0]       out_sat,
    output logic [CHANNELS-1:0]       out_nan
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SH_W  = 16 + OUT_W + FRAC_BITS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [SH_W-1:0]  LIM_NEG  = SH_W'(1) << (OUT_W - 1);
    localparam logic [SH_W-1:0]  LIM_POS  = LIM_NEG - SH_W'(1);
    localparam logic [OUT_W-1:0] MAX_VAL  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_VAL  = {1'b1, {(OUT_W-1){1'b0}}};

    // value = mant * 2^(exp_eff - 25 + FRAC_BITS); 25 = bias 15 + 10 fraction bits
    localparam logic [6:0] SHIFT_ZERO = 7'd25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]      idx_reg;
    logic [16*CHANNELS-1:0] batch_reg;

    logic load_en;
    logic conv_en;

    logic [15:0] batch_lane [CHANNELS];
    logic [15:0] cur_half;

    logic             cur_sign;
    logic [4:0]       cur_exp;
    logic [9:0]       cur_frac;
    logic [10:0]      mant;
    logic [4:0]       exp_eff;
    logic [6:0]       shift_pos;
    logic [SH_W-1:0]  mag;
    logic [OUT_W-1:0] conv_val;
    logic             conv_sat;
    logic             conv_nan;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid)          state_next = CONV;
            CONV: if (idx_reg == LAST_IDX) state_next = DONE;
            DONE: if (out_ready)         state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_en   = 1'b0;
        conv_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                load_en  = in_valid;
            end
            CONV:    conv_en   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- batch capture and lane index ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_reg <= '0;
            idx_reg   <= '0;
        end else if (load_en) begin
            batch_reg <= in_data;
            idx_reg   <= '0;
        end else if (conv_en) begin
            idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
    end

    assign cur_half = batch_lane[idx_reg];

    // ---------------- shared converter ----------------
    always_comb begin
        cur_sign  = cur_half[15];
        cur_exp   = cur_half[14:10];
        cur_frac  = cur_half[9:0];
        mant      = {(cur_exp != 5'd0), cur_frac};
        // subnormals share the exponent of the smallest normal, without the hidden bit
        exp_eff   = (cur_exp == 5'd0) ? 5'd1 : cur_exp;
        shift_pos = 7'(exp_eff) + 7'(FRAC_BITS);

        if (shift_pos >= SHIFT_ZERO) begin
            mag = SH_W'(mant) << (shift_pos - SHIFT_ZERO);
        end else begin
            mag = SH_W'(mant) >> (SHIFT_ZERO - shift_pos);
        end

        conv_sat = 1'b0;
        conv_nan = 1'b0;
        conv_val = cur_sign ? ({OUT_W{1'b0}} - mag[OUT_W-1:0]) : mag[OUT_W-1:0];

        if (cur_exp == 5'h1F) begin
            if (cur_frac != 10'd0) begin
                conv_nan = 1'b1;
                conv_val = '0;
            end else begin
                conv_sat = 1'b1;
                conv_val = cur_sign ? MIN_VAL : MAX_VAL;
            end
        end else if (!cur_sign && (mag > LIM_POS)) begin
            conv_sat = 1'b1;
            conv_val = MAX_VAL;
        end else if (cur_sign && (mag > LIM_NEG)) begin
            conv_sat = 1'b1;
            conv_val = MIN_VAL;
        end
    end

    // ---------------- per-lane result registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [OUT_W-1:0] res_reg;
            logic             sat_reg;
            logic             nan_reg;

            assign batch_lane[gi] = batch_reg[16*gi +: 16];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_reg <= '0;
                    sat_reg <= 1'b0;
                    nan_reg <= 1'b0;
                end else if (conv_en && (idx_reg == IDX_W'(gi))) begin
                    res_reg <= conv_val;
                    sat_reg <= conv_sat;
                    nan_reg <= conv_nan;
                end
            end

            assign out_data[OUT_W*gi +: OUT_W] = res_reg;
            assign out_sat[gi]                 = sat_reg;
            assign out_nan[gi]                 = nan_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fp16_to_fixed_seq.sv
// Self-checking bench: two instances (FRAC_BITS 0 and 4) checked against a
// real-arithmetic reference model of FP16 -> fixed conversion.
module tb_fp16_to_fixed_seq;

    localparam int CH = 4;
    localparam int OW = 16;

    localparam logic [63:0] V029_IN  = 64'h3800_3C00_C500_5A00;
    localparam logic [63:0] V029_OUT = 64'h0000_0001_FFFB_00C0;
    localparam logic [63:0] V030_IN  = 64'h7BFF_7E00_FC00_7C00;
    localparam logic [63:0] V030_OUT = 64'h7FFF_0000_8000_7FFF;
    localparam logic [63:0] V031_IN  = 64'h8000_0001_BE00_3E00;
    localparam logic [63:0] V031_OUT = 64'h0000_0000_FFE8_0018;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    logic        iv0, iv1, ir0, ir1, ov0, ov1;
    logic [63:0] od0, od1;
    logic [3:0]  sat0, sat1, nan0, nan1;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_sat, out_nan;

    assign iv0       = in_valid && (sel == 0);
    assign iv1       = in_valid && (sel == 1);
    assign in_ready  = (sel == 1) ? ir1  : ir0;
    assign out_valid = (sel == 1) ? ov1  : ov0;
    assign out_data  = (sel == 1) ? od1  : od0;
    assign out_sat   = (sel == 1) ? sat1 : sat0;
    assign out_nan   = (sel == 1) ? nan1 : nan0;

    fp16_to_fixed_seq #(.CHANNELS(CH), .OUT_W(OW), .FRAC_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(sat0), .out_nan(nan0)
    );

    fp16_to_fixed_seq #(.CHANNELS(CH), .OUT_W(OW), .FRAC_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(sat1), .out_nan(nan1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic void model(input logic [15:0] h, input int fb,
                                  output logic [15:0] v, output logic s, output logic n);
        int     e, f;
        real    mag_r;
        longint mag;
        e = int'(h[14:10]);
        f = int'(h[9:0]);
        v = '0;
        s = 1'b0;
        n = 1'b0;
        if (e == 31) begin
            if (f != 0) n = 1'b1;
            else begin
                s = 1'b1;
                v = h[15] ? 16'h8000 : 16'h7FFF;
            end
        end else begin
            if (e == 0) mag_r = (real'(f) / 1024.0) * pow2(fb - 14);
            else        mag_r = (1.0 + real'(f) / 1024.0) * pow2(e - 15 + fb);
            mag = longint'($floor(mag_r));
            if (!h[15]) begin
                if (mag > 32767) begin s = 1'b1; v = 16'h7FFF; end
                else v = 16'(mag);
            end else begin
                if (mag > 32768) begin s = 1'b1; v = 16'h8000; end
                else v = 16'(-mag);
            end
        end
    endfunction

    function automatic void expect_batch(input logic [63:0] d, input int fb,
                                         output logic [63:0] ed, output logic [3:0] es,
                                         output logic [3:0] en);
        logic [15:0] v;
        logic        s, n;
        ed = '0;
        es = '0;
        en = '0;
        for (int i = 0; i < CH; i++) begin
            model(d[16*i +: 16], fb, v, s, n);
            ed[16*i +: 16] = v;
            es[i] = s;
            en[i] = n;
        end
    endfunction

    function automatic logic [15:0] rand_half();
        logic       sgn;
        logic [4:0] e;
        logic [9:0] f;
        sgn = 1'($urandom_range(0, 1));
        e   = 5'($urandom_range(0, 31));
        f   = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
        return {sgn, e, f};
    endfunction

    function automatic logic [63:0] rand_batch();
        logic [63:0] d;
        for (int i = 0; i < CH; i++) d[16*i +: 16] = rand_half();
        return d;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Caller is at posedge+1 with the selected instance idle.
    task automatic drive_batch(input logic [63:0] d, output int cyc);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0/0", ov0, ov1); end
        checks++; if (od0 !== 64'h0 || od1 !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h/%h want 0", od0, od1); end
        checks++; if (sat0 !== 4'h0 || nan0 !== 4'h0 || sat1 !== 4'h0 || nan1 !== 4'h0) begin errors++; $display("FAIL reset_flags: got sat %b/%b nan %b/%b want 0", sat0, sat1, nan0, nan1); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir0 !== 1'b1 || ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", ir0, ir1); end
        $display("reset: in_ready=%b/%b out_valid=%b/%b", ir0, ir1, ov0, ov1);
    endtask

    task automatic test_vectors();
        logic [63:0] vin [3];
        logic [63:0] vout [3];
        logic [3:0]  vsat [3];
        logic [3:0]  vnan [3];
        int          vsel [3];
        int          cyc;
        vin[0] = V029_IN; vout[0] = V029_OUT; vsat[0] = 4'b0000; vnan[0] = 4'b0000; vsel[0] = 0;
        vin[1] = V030_IN; vout[1] = V030_OUT; vsat[1] = 4'b1011; vnan[1] = 4'b0100; vsel[1] = 0;
        vin[2] = V031_IN; vout[2] = V031_OUT; vsat[2] = 4'b0000; vnan[2] = 4'b0000; vsel[2] = 1;
        for (int k = 0; k < 3; k++) begin
            sel = vsel[k];
            drive_batch(vin[k], cyc);
            checks++; if (cyc != CH) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", k, cyc, CH); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL vec%0d_in_ready_done: got %b want 0", k, in_ready); end
            checks++; if (out_data !== vout[k]) begin errors++; $display("FAIL vec%0d_data: got %h want %h", k, out_data, vout[k]); end
            checks++; if (out_sat !== vsat[k] || out_nan !== vnan[k]) begin errors++; $display("FAIL vec%0d_flags: got sat=%b nan=%b want sat=%b nan=%b", k, out_sat, out_nan, vsat[k], vnan[k]); end
            $display("vector %0d: in=%h out=%h sat=%b nan=%b", k, vin[k], out_data, out_sat, out_nan);
            drain();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_return_idle: got valid=%b ready=%b want 0/1", k, out_valid, in_ready); end
        end
        sel = 0;
    endtask

    task automatic test_random();
        logic [63:0] d, ed;
        logic [3:0]  es, en;
        int          cyc, fb;
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 1));
            fb  = (sel == 1) ? 4 : 0;
            d   = rand_batch();
            expect_batch(d, fb, ed, es, en);
            drive_batch(d, cyc);
            checks++; if (cyc != CH) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", k, cyc, CH); end
            checks++; if (out_data !== ed || out_sat !== es || out_nan !== en) begin
                errors++;
                $display("FAIL rand%0d_result fb=%0d in=%h: got %h sat=%b nan=%b want %h sat=%b nan=%b", k, fb, d, out_data, out_sat, out_nan, ed, es, en);
            end
            $display("random %0d fb=%0d: in=%h out=%h sat=%b nan=%b", k, fb, d, out_data, out_sat, out_nan);
            drain();
        end
        sel = 0;
    endtask

    task automatic test_backpressure();
        int          cyc;
        logic [63:0] held;
        sel = 0;
        drive_batch(V029_IN, cyc);
        held = out_data;
        checks++; if (held !== V029_OUT) begin errors++; $display("FAIL bp_initial_data: got %h want %h", held, V029_OUT); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== V029_OUT) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h want 1/0/%h", i, out_valid, in_ready, out_data, V029_OUT);
            end
        end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        $display("backpressure: held %h for 5 cycles, released", held);
    endtask

    task automatic test_reset_mid();
        int cyc;
        sel = 0;
        in_valid = 1'b1;
        in_data  = V029_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (out_data[31:0] !== 32'hFFFB_00C0) begin errors++; $display("FAIL rstmid_partial: got %h want fffb00c0", out_data[31:0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sat !== 4'h0 || out_nan !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got valid=%b data=%h sat=%b nan=%b want 0", out_valid, out_data, out_sat, out_nan);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        drive_batch(V029_IN, cyc);
        checks++; if (cyc != CH || out_data !== V029_OUT || out_sat !== 4'h0 || out_nan !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_after: got lat=%0d data=%h sat=%b nan=%b want %0d %h 0 0", cyc, out_data, out_sat, out_nan, CH, V029_OUT);
        end
        $display("reset mid-batch: recovered out=%h", out_data);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] qd [$];
        logic [3:0]  qs [$];
        logic [3:0]  qn [$];
        logic [63:0] cur, ed, snap_d;
        logic [3:0]  es, en, snap_s, snap_n;
        logic        acc, fin;
        int          n_acc, n_done, last_acc, cyc;
        n_acc = 0; n_done = 0; last_acc = -1; cyc = 0;
        sel = 0;
        out_ready = 1'b1;
        cur = rand_batch();
        in_data  = cur;
        in_valid = 1'b1;
        while (n_done < 6 && cyc < 200) begin
            acc    = in_ready && in_valid;
            fin    = out_valid && out_ready;
            snap_d = out_data;
            snap_s = out_sat;
            snap_n = out_nan;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                expect_batch(cur, 0, ed, es, en);
                qd.push_back(ed); qs.push_back(es); qn.push_back(en);
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != CH + 2) begin errors++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, CH + 2); end
                end
                last_acc = cyc;
                n_acc++;
                cur = rand_batch();
                in_data = cur;
                if (n_acc == 6) in_valid = 1'b0;
            end
            if (fin) begin
                if (qd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_extra_output: got %h want none", snap_d);
                end else begin
                    ed = qd.pop_front(); es = qs.pop_front(); en = qn.pop_front();
                    checks++; if (snap_d !== ed || snap_s !== es || snap_n !== en) begin
                        errors++;
                        $display("FAIL b2b_result%0d: got %h sat=%b nan=%b want %h sat=%b nan=%b", n_done, snap_d, snap_s, snap_n, ed, es, en);
                    end
                    $display("back-to-back %0d: out=%h sat=%b nan=%b", n_done, snap_d, snap_s, snap_n);
                end
                n_done++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (n_acc != 6 || n_done != 6 || qd.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got acc=%0d done=%0d pending=%0d want 6/6/0", n_acc, n_done, qd.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp16_to_fixed_seq.md
FP16_TO_FIXED_SEQ -- requirements
Module: fp16_to_fixed_seq

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, meaning the number of FP16 lanes per batch (range 1..8).
REQ-002 SHALL provide parameter OUT_W, default 16, meaning the signed two's-complement output width per lane (range 8..32).
REQ-003 SHALL provide parameter FRAC_BITS, default 0, meaning the fractional bits in each output (range 0..OUT_W-2); 0 gives plain integer output.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input batch is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a batch this cycle.
REQ-008 SHALL have port in_data, input, 16*CHANNELS bits: IEEE-754 half-precision values, lane i at [16*i+15:16*i].
REQ-009 SHALL have port out_valid, output, 1 bit: the result batch is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_data, output, OUT_W*CHANNELS bits: fixed-point results, lane i at [OUT_W*i+OUT_W-1:OUT_W*i].
REQ-012 SHALL have port out_sat, output, CHANNELS bits: per lane, the result was saturated (overflow or infinity).
REQ-013 SHALL have port out_nan, output, CHANNELS bits: per lane, the input was NaN.

Function
REQ-014 SHALL implement FSM states IDLE, CONV and DONE, using one shared converter that processes one lane per cycle.
REQ-015 IDLE: in_ready=1 and out_valid=0; when in_valid=1, the block SHALL register all of in_data, set lane index to 0 and go to CONV.
REQ-016 CONV: each cycle the block SHALL convert lane index, write its out_data slice, out_sat bit and out_nan bit, then increment the index; after lane CHANNELS-1 it SHALL go to DONE.
REQ-017 DONE: out_valid=1; out_data, out_sat and out_nan SHALL stay stable until out_valid&out_ready, then the block SHALL go to IDLE.
REQ-018 Latency: out_valid SHALL rise exactly CHANNELS cycles after the accepting edge; in_ready SHALL return 1 the cycle after the output handshake.
REQ-019 in_ready SHALL be 0 in CONV and DONE; in_data changes outside IDLE SHALL have no effect.
REQ-020 Normal input (exp 1..30): magnitude SHALL equal (1.frac) * 2^(exp-15) scaled by 2^FRAC_BITS, truncated toward zero.
REQ-021 Subnormal input (exp 0): magnitude SHALL equal (0.frac) * 2^-14 scaled by 2^FRAC_BITS, truncated toward zero; +0 and -0 SHALL both give 0.
REQ-022 Sign bit set: output SHALL be the two's-complement negation of the magnitude (truncation is on the magnitude, so rounding is toward zero).
REQ-023 Magnitude above 2^(OUT_W-1)-1 (positive) or above 2^(OUT_W-1) (negative): output SHALL clamp to max (0x7FFF at OUT_W=16) or min (0x8000) and set out_sat.
REQ-024 Infinity (exp 31, frac 0): output SHALL be the signed clamp value and out_sat SHALL be set.
REQ-025 NaN (exp 31, frac != 0): output SHALL be 0, out_nan SHALL be set, and out_sat SHALL be clear.
REQ-026 Internal shift width SHALL be at least 16+OUT_W+FRAC_BITS bits so no intermediate bit is lost before the saturation check.

Reset
REQ-027 When rst_n=0, the block SHALL immediately enter IDLE, clear the lane index, drive out_valid=0, and zero out_data, out_sat and out_nan; in_ready SHALL be 1 once rst_n=1.
REQ-028 Reset asserted during CONV or DONE SHALL abandon the batch; the first batch accepted after reset SHALL convert correctly.

Verification (CHANNELS=4, OUT_W=16 unless stated)
REQ-029 FRAC_BITS=0, lanes {0x5A00, 0xC500, 0x3C00, 0x3800} -> after 4 cycles out_data lanes {0x00C0, 0xFFFB, 0x0001, 0x0000}; flags 0.
REQ-030 FRAC_BITS=0, lanes {0x7C00, 0xFC00, 0x7E00, 0x7BFF} -> {0x7FFF, 0x8000, 0x0000, 0x7FFF}; out_sat=4'b1011, out_nan=4'b0100.
REQ-031 FRAC_BITS=4, lanes {0x3E00, 0xBE00, 0x0001, 0x8000} -> {0x0018, 0xFFE8, 0x0000, 0x0000}; flags 0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low during CONV (lane 2) -> out_valid=0 and outputs zero immediately; a new batch afterwards converts per REQ-029.
REQ-034 Back-to-back: in_valid held high with out_ready=1 -> batches accepted every CHANNELS+2 cycles, with no lost or duplicated batch.
